// File: rtl/data_sequencer_if.sv
// Command handshake and data-line strobe bundle between upstream and data_sequencer.
// Latency: none (wires only).
// Backpressure: CMD_READY from the sequencer; no queueing.
// Ports: CMD_VALID/CMD_OP/CMD_COUNT/CMD_READY handshake; ADDRESS plus LOAD/INC/DEC/STORE/DONE outputs.
interface data_sequencer_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int COUNT_WIDTH   = 8
);
    logic                     CMD_VALID;
    logic                     CMD_READY;
    logic [1:0]               CMD_OP;
    logic [COUNT_WIDTH-1:0]   CMD_COUNT;
    logic [ADDRESS_WIDTH-1:0] ADDRESS;
    logic                     LOAD;
    logic                     INC;
    logic                     DEC;
    logic                     STORE;
    logic                     DONE;

    // Upstream command source / data line side.
    modport master (
        output CMD_VALID, CMD_OP, CMD_COUNT,
        input  CMD_READY, ADDRESS, LOAD, INC, DEC, STORE, DONE
    );

    // Sequencer side.
    modport slave (
        input  CMD_VALID, CMD_OP, CMD_COUNT,
        output CMD_READY, ADDRESS, LOAD, INC, DEC, STORE, DONE
    );
endinterface

// File: rtl/data_sequencer.sv
// Run-length tape command sequencer: owns the data pointer, drives LOAD/INC/DEC/STORE to the data line.
// Latency: data op N -> N+2 busy cycles (DONE with STORE); pointer op N -> N busy cycles; count 0 -> DONE next cycle.
// Backpressure: CMD_READY high only in IDLE; CMD_VALID while busy is ignored.
// Ports: CLOCK, RST (async active-low), bus (data_sequencer_if.slave: command handshake + data-line strobes).
module data_sequencer #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int MAX_ADDRESS   = 29999,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic            CLOCK,
    input  logic            RST,
    data_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_MOD,
        S_ST,
        S_STEP
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] MAX_A = ADDRESS_WIDTH'(MAX_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] A_ONE = ADDRESS_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]   C_ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]   C_TWO = COUNT_WIDTH'(2);

    state_t                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    // Only CMD_OP[0] is kept: the state already tells data op from pointer op.
    // 0 = INC / move right, 1 = DEC / move left.
    logic                     op_q, op_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     load_q, load_d;
    logic                     inc_q, inc_d;
    logic                     dec_q, dec_d;
    logic                     store_q, store_d;
    logic                     done_q, done_d;
    logic                     rdy_q, rdy_d;
    logic                     accept;

    // Pointer move with wrap at both ends of the tape.
    function automatic logic [ADDRESS_WIDTH-1:0] step_addr(
        input logic [ADDRESS_WIDTH-1:0] a,
        input logic                     left
    );
        logic [ADDRESS_WIDTH-1:0] r;
        if (left) r = (a == '0) ? MAX_A : a - A_ONE;
        else      r = (a == MAX_A) ? '0 : a + A_ONE;
        return r;
    endfunction

    // Outputs are registered, so every *_d below is the value seen in the
    // cycle after the current edge.
    always_comb begin
        accept  = bus.CMD_VALID && rdy_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        load_d  = 1'b0;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        store_d = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = bus.CMD_OP[0];
                    cnt_d = bus.CMD_COUNT;
                    if (bus.CMD_COUNT == '0) begin
                        done_d = 1'b1;
                    end else if (!bus.CMD_OP[1]) begin
                        state_d = S_LD;
                        load_d  = 1'b1;
                    end else begin
                        // First pointer move lands in the cycle right after acceptance.
                        state_d = S_STEP;
                        addr_d  = step_addr(addr_q, bus.CMD_OP[0]);
                        done_d  = (bus.CMD_COUNT == C_ONE);
                    end
                end
            end
            S_LD: begin
                state_d = S_MOD;
                inc_d   = !op_q;
                dec_d   = op_q;
            end
            S_MOD: begin
                // The strobe for this cycle is already out; cnt==1 means it was the last one.
                cnt_d = cnt_q - C_ONE;
                if (cnt_q == C_ONE) begin
                    state_d = S_ST;
                    store_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    inc_d = !op_q;
                    dec_d = op_q;
                end
            end
            S_ST: begin
                state_d = S_IDLE;
            end
            S_STEP: begin
                cnt_d = cnt_q - C_ONE;
                if (cnt_q == C_ONE) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d = step_addr(addr_q, op_q);
                    done_d = (cnt_q == C_TWO);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            load_q  <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            store_q <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            load_q  <= load_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            store_q <= store_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.CMD_READY = rdy_q;
    assign bus.ADDRESS   = addr_q;
    assign bus.LOAD      = load_q;
    assign bus.INC       = inc_q;
    assign bus.DEC       = dec_q;
    assign bus.STORE     = store_q;
    assign bus.DONE      = done_q;
endmodule

// File: tb/tb_data_sequencer.sv
// Self-checking bench for data_sequencer: table of commands with hand-derived results,
// randomized commands against a cycle-timeline model, and hand sequences for reset abort and busy hold.
module tb_data_sequencer;
    localparam int AW   = 16;
    localparam int CW   = 8;
    localparam int MAXA = 29999;
    localparam int TAPE = MAXA + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_sequencer_if #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

    data_sequencer #(
        .ADDRESS_WIDTH(AW),
        .MAX_ADDRESS  (MAXA),
        .COUNT_WIDTH  (CW)
    ) dut (
        .CLOCK(clk),
        .RST  (rst_n),
        .bus  (bus)
    );

    // Behavioural data line: samples strobes on negedge.
    byte unsigned tape [TAPE];
    byte unsigned dcnt;
    int           store_cnt;
    always @(negedge clk) begin
        if (bus.LOAD)  dcnt <= tape[bus.ADDRESS];
        if (bus.INC)   dcnt <= dcnt + 8'd1;
        if (bus.DEC)   dcnt <= dcnt - 8'd1;
        if (bus.STORE) begin
            tape[bus.ADDRESS] <= dcnt;
            store_cnt         <= store_cnt + 1;
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic ld, inc, dec, st, dn, rdy;
    } obs_t;

    typedef struct {
        int op;
        int n;
        int exp_addr;
        int exp_cell;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   model_addr = 0;
    int   exp_tape [TAPE];
    obs_t exp_q [$];

    function automatic obs_t mk(int a, bit ld, bit inc, bit dec, bit st, bit dn, bit rdy);
        obs_t o;
        o.addr = AW'(a);
        o.ld = ld; o.inc = inc; o.dec = dec; o.st = st; o.dn = dn; o.rdy = rdy;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.addr = bus.ADDRESS;
        o.ld = bus.LOAD; o.inc = bus.INC; o.dec = bus.DEC;
        o.st = bus.STORE; o.dn = bus.DONE; o.rdy = bus.CMD_READY;
        return o;
    endfunction

    task automatic check_obs(string name, int cyc, obs_t want);
        obs_t got;
        got = sample();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got a=%0d ld=%b inc=%b dec=%b st=%b dn=%b rdy=%b want a=%0d ld=%b inc=%b dec=%b st=%b dn=%b rdy=%b",
                     name, cyc, got.addr, got.ld, got.inc, got.dec, got.st, got.dn, got.rdy,
                     want.addr, want.ld, want.inc, want.dec, want.st, want.dn, want.rdy);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Expected per-cycle outputs after acceptance, straight from the command timing rules.
    function automatic void build_exp(int op, int n);
        exp_q.delete();
        if (n == 0) begin
            exp_q.push_back(mk(model_addr, 0, 0, 0, 0, 1, 1));
        end else if (op < 2) begin
            exp_q.push_back(mk(model_addr, 1, 0, 0, 0, 0, 0));
            for (int k = 0; k < n; k++)
                exp_q.push_back(mk(model_addr, 0, op == 0, op == 1, 0, 0, 0));
            exp_q.push_back(mk(model_addr, 0, 0, 0, 1, 1, 0));
            exp_tape[model_addr] = (op == 0) ? ((exp_tape[model_addr] + n) & 255)
                                             : ((exp_tape[model_addr] - n) & 255);
        end else begin
            for (int k = 1; k <= n; k++) begin
                model_addr = (op == 2) ? (model_addr + 1) % TAPE : (model_addr + TAPE - 1) % TAPE;
                exp_q.push_back(mk(model_addr, 0, 0, 0, 0, k == n, 0));
            end
        end
    endfunction

    // Entered away from posedge with the DUT idle; returns at the negedge of the idle cycle after completion.
    task automatic run_cmd(string name, int op, int n);
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = op[1:0];
        bus.CMD_COUNT = n[CW-1:0];
        @(posedge clk); #1;
        bus.CMD_VALID = 1'b0;
        build_exp(op, n);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check_obs(name, i + 1, exp_q[i]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_obs({name, " idle"}, exp_q.size() + 1, mk(model_addr, 0, 0, 0, 0, 0, 1));
        if (op < 2 && n > 0)
            check_int({name, " cell"}, int'(tape[model_addr]), exp_tape[model_addr]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        int   sc;
        int   old_addr;

        vecs[0] = '{0, 3,   0,     3};
        vecs[1] = '{0, 0,   0,     3};
        vecs[2] = '{2, 5,   5,     0};
        vecs[3] = '{1, 2,   5,     254};
        vecs[4] = '{3, 5,   0,     3};
        vecs[5] = '{3, 1,   29999, 0};
        vecs[6] = '{2, 2,   1,     0};
        vecs[7] = '{1, 1,   1,     255};
        vecs[8] = '{3, 2,   29999, 0};
        vecs[9] = '{0, 7,   29999, 7};

        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = 2'b00;
        bus.CMD_COUNT = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_obs("reset", 0, mk(0, 0, 0, 0, 0, 0, 1));
        rst_n = 1'b1;
        @(negedge clk);
        check_obs("post reset idle", 0, mk(0, 0, 0, 0, 0, 0, 1));

        // Table-driven commands with hand-derived pointer and cell results
        for (int i = 0; i < 10; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].n);
            check_int($sformatf("vec%0d addr", i), int'(bus.ADDRESS), vecs[i].exp_addr);
            check_int($sformatf("vec%0d tape", i), int'(tape[vecs[i].exp_addr]), vecs[i].exp_cell);
        end

        // Busy hold: only the first command runs, the next is taken the cycle READY returns
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = 2'b00;
        bus.CMD_COUNT = 8'd2;
        @(posedge clk);
        build_exp(0, 2);
        foreach (exp_q[i]) begin
            #1;
            bus.CMD_OP    = 2'($urandom_range(0, 3));
            bus.CMD_COUNT = 8'($urandom_range(0, 255));
            @(negedge clk);
            check_obs("busy data", i + 1, exp_q[i]);
            @(posedge clk);
        end
        #1;
        bus.CMD_OP    = 2'b10;
        bus.CMD_COUNT = 8'd3;
        @(negedge clk);
        check_obs("busy ready back", 5, mk(model_addr, 0, 0, 0, 0, 0, 1));
        @(posedge clk); #1;
        bus.CMD_VALID = 1'b0;
        build_exp(2, 3);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check_obs("busy step", i + 6, exp_q[i]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_obs("busy end idle", 9, mk(model_addr, 0, 0, 0, 0, 0, 1));
        check_int("busy tape", int'(tape[model_addr]), exp_tape[model_addr]);

        // Reset in the middle of MOD: strobes drop with no clock edge, no STORE
        old_addr = model_addr;
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = 2'b00;
        bus.CMD_COUNT = 8'd10;
        @(posedge clk); #1;
        bus.CMD_VALID = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_obs("mid MOD inc", 2, mk(old_addr, 0, 1, 0, 0, 0, 0));
        sc = store_cnt;
        #2 rst_n = 1'b0;
        #1;
        check_obs("async abort", 0, mk(0, 0, 0, 0, 0, 0, 1));
        @(posedge clk);
        @(negedge clk);
        check_obs("abort held", 0, mk(0, 0, 0, 0, 0, 0, 1));
        check_int("abort no store", store_cnt, sc);
        check_int("abort tape", int'(tape[old_addr]), exp_tape[old_addr]);
        rst_n = 1'b1;
        model_addr = 0;
        @(negedge clk);
        check_obs("after abort idle", 0, mk(0, 0, 0, 0, 0, 0, 1));

        // Randomized commands against the timeline model
        for (int i = 0; i < 60; i++) begin
            int op, n;
            op = $urandom_range(0, 3);
            n  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
            run_cmd($sformatf("rnd%0d op%0d n%0d", i, op, n), op, n);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                @(negedge clk);
                check_obs("rnd gap", 0, mk(model_addr, 0, 0, 0, 0, 0, 1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
